// File: rtl/alu_flags_stage_pkg.sv
// Shared ALU definitions: op encodings, condition codes, status bit layout.
package alu_flags_stage_pkg;

    // ALU operation encodings used by the execute stage feeding this block.
    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpMov = 4'd5
    } alu_op_e;

    // Status register bit positions.
    localparam int unsigned STATUS_C = 0;
    localparam int unsigned STATUS_Z = 1;
    localparam int unsigned STATUS_N = 2;
    localparam int unsigned STATUS_W = 3;

    // Condition codes; every encoding from COND_NV upwards never passes.
    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_HI = 4'd7;
    localparam logic [3:0] COND_LS = 4'd8;
    localparam logic [3:0] COND_NV = 4'd9;

    // Evaluate a condition code against the current status bits.
    function automatic logic cond_pass(input logic [3:0]          cond,
                                       input logic [STATUS_W-1:0] st);
        logic c, z, n;
        c = st[STATUS_C];
        z = st[STATUS_Z];
        n = st[STATUS_N];
        case (cond)
            COND_AL: cond_pass = 1'b1;
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_HI: cond_pass = c & !z;
            COND_LS: cond_pass = !c | z;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_flags_stage_skid_fifo2.sv
// Two-entry FIFO with registered count; full depends only on state, so the
// upstream ready never combinationally depends on the downstream ready.
module skid_fifo2 #(
    parameter int unsigned DW = 33
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    output logic          full_o,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && valid_o;

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count; pointers are 1 bit and wrap modulo 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_flags_stage.sv
// ALU writeback flags stage: evaluates the condition code against the status
// register, updates flags, and buffers {result, pass} for the consumer.
module alu_flags_stage
    import alu_flags_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_status,
    input  logic             in_set_flags,
    input  logic [3:0]       in_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_write,
    input  logic             flags_we,
    input  logic [2:0]       flags_d,
    output logic [2:0]       flags_q,
    output logic             carry_out
);

    logic [STATUS_W-1:0] status_q;
    logic [STATUS_W-1:0] status_d;
    logic                accept;
    logic                pass;
    logic                fifo_full;
    logic                fifo_valid;
    logic [WIDTH:0]      head;

    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign pass      = cond_pass(in_cond, status_q);
    assign flags_q   = status_q;
    assign carry_out = status_q[STATUS_C];

    // Direct writes win over an op's flag update in the same cycle.
    always_comb begin
        status_d = status_q;
        if (flags_we) begin
            status_d = flags_d;
        end else if (accept && pass && in_set_flags) begin
            status_d = in_status;
        end
    end

    // Status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    skid_fifo2 #(
        .DW (WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (accept),
        .data_i  ({pass, in_result}),
        .full_o  (fifo_full),
        .pop_i   (out_ready),
        .valid_o (fifo_valid),
        .data_o  (head)
    );

    assign out_valid  = fifo_valid;
    assign out_result = head[WIDTH-1:0];
    // Gate with valid so a popped entry's pass bit never leaks out.
    assign out_write  = fifo_valid && head[WIDTH];

endmodule
